// File: rtl/id_pkg.sv
// Package: id_pkg
// Shared types and encodings for the RV32 decode stage (id_stage_pipe).
//   - RV32 base opcode localparams
//   - operand / writeback selector encodings
//   - id_ctrl_t: control bundle carried in the ID/EX register
package id_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } src_a_sel_e;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_sel_e;

    typedef enum logic [1:0] {
        WD3_ALU = 2'd0,
        WD3_MEM = 2'd1,
        WD3_PC4 = 2'd2
    } wd3_sel_e;

    typedef struct packed {
        src_a_sel_e src_a_sel;
        src_b_sel_e src_b_sel;
        wd3_sel_e   wd3_sel;
        logic       we3;
        logic       wem;
        logic       is_branch_op;
        logic       is_jump;
        logic       is_load;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       illegal;
    } id_ctrl_t;

endpackage

// File: rtl/id_hazard_unit.sv
// Module: id_hazard_unit
// Detects the two conditions that stop the decode stage from accepting an
// instruction:
//   lu  : load in the ID/EX register writes a register this instruction reads
//   wbh : WB writes a register this instruction reads in the same cycle
//         (only when the WB->ID write-through is not built; ID_BYPASS_EN
//         removes it)
// Ports:
//   ra1, ra2, uses_rs1, uses_rs2 : source registers of the instruction in ID
//   ex_valid, ex_is_load, ex_wa3 : ID/EX register contents
//   wb_we3, wb_wa3               : writeback port
//   lu, wbh                      : hazard flags
module id_hazard_unit (
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] ra1,
    input  logic [4:0] ra2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_wa3,
    input  logic       wb_we3,
    input  logic [4:0] wb_wa3,
    output logic       lu,
    output logic       wbh
);

    // x0 is never a producer, so a zero destination can never stall
    assign lu = ex_valid && ex_is_load && (ex_wa3 != 5'd0) &&
                ((ex_wa3 == ra1 && uses_rs1) || (ex_wa3 == ra2 && uses_rs2));

`ifdef ID_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_we3, wb_wa3};
    assign wbh = 1'b0;
`else
    assign wbh = wb_we3 && (wb_wa3 != 5'd0) &&
                 ((wb_wa3 == ra1 && uses_rs1) || (wb_wa3 == ra2 && uses_rs2));
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Module: id_stage_pipe
// RV32 decode stage with ID/EX pipeline register and valid/ready on both sides.
// Decodes instr, reads the register file, stalls IF on load-use / WB hazards
// and inserts bubbles into EX. flush (taken branch in EX) kills the ID/EX
// register and the incoming instruction.
// Optional feature: define ID_BYPASS_EN for WB->ID write-through (removes the
// WB hazard stall); otherwise the register file is read-before-write.
// Ports:
//   clk, reset (async, active-high)
//   IF side : in_valid, in_ready, instr, pc_in
//   EX side : out_valid, out_ready, ctrl_out, wa3_out, imm, rd1, rd2, pc_out
//   WB side : we3_in, wa3_in, wd3_in
//   flush   : EX redirect
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output id_ctrl_t        ctrl_out,
    output logic [4:0]      wa3_out,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] pc_out,
    input  logic            we3_in,
    input  logic [4:0]      wa3_in,
    input  logic [XLEN-1:0] wd3_in
);

    localparam int AW = $clog2(NREGS);

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [4:0]        ra1, ra2, rd_idx;
    logic              uses_rs1, uses_rs2, has_rd;
    id_ctrl_t          ctrl_dec;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   rd1_val, rd2_val;
    logic              lu, wbh;
    logic [XLEN-1:0]   rf [NREGS];

    logic              vld_p1;
    id_ctrl_t          ctrl_p1;
    logic [4:0]        wa3_p1;
    logic [XLEN-1:0]   imm_p1, rd1_p1, rd2_p1, pc_p1;

    assign ra1    = instr[19:15];
    assign ra2    = instr[24:20];
    assign rd_idx = instr[11:7];

    // ---------------- ID: decode ----------------
    always_comb begin
        ctrl_dec        = '0;
        ctrl_dec.funct3 = instr[14:12];
        ctrl_dec.funct7 = instr[31:25];
        uses_rs1        = 1'b0;
        uses_rs2        = 1'b0;
        has_rd          = 1'b0;
        imm32           = '0;
        case (instr[6:0])
            OP_LOAD: begin
                uses_rs1 = 1'b1; has_rd = 1'b1;
                ctrl_dec.we3 = 1'b1; ctrl_dec.is_load = 1'b1;
                ctrl_dec.src_b_sel = SRC_B_IMM; ctrl_dec.wd3_sel = WD3_MEM;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                ctrl_dec.wem = 1'b1; ctrl_dec.src_b_sel = SRC_B_IMM;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                ctrl_dec.is_branch_op = 1'b1;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_IMM: begin
                uses_rs1 = 1'b1; has_rd = 1'b1;
                ctrl_dec.we3 = 1'b1; ctrl_dec.src_b_sel = SRC_B_IMM;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_REG: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_rd = 1'b1;
                ctrl_dec.we3 = 1'b1;
            end
            OP_LUI: begin
                has_rd = 1'b1; ctrl_dec.we3 = 1'b1;
                ctrl_dec.src_a_sel = SRC_A_ZERO; ctrl_dec.src_b_sel = SRC_B_IMM;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                has_rd = 1'b1; ctrl_dec.we3 = 1'b1;
                ctrl_dec.src_a_sel = SRC_A_PC; ctrl_dec.src_b_sel = SRC_B_IMM;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                has_rd = 1'b1; ctrl_dec.we3 = 1'b1; ctrl_dec.is_jump = 1'b1;
                ctrl_dec.src_a_sel = SRC_A_PC; ctrl_dec.src_b_sel = SRC_B_IMM;
                ctrl_dec.wd3_sel = WD3_PC4;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_JALR: begin
                uses_rs1 = 1'b1; has_rd = 1'b1;
                ctrl_dec.we3 = 1'b1; ctrl_dec.is_jump = 1'b1;
                ctrl_dec.src_b_sel = SRC_B_IMM; ctrl_dec.wd3_sel = WD3_PC4;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            default: ctrl_dec.illegal = 1'b1;
        endcase
        // Register index outside the implemented file (RV32E): let it flow
        // through as an illegal no-op so EX can trap on it
        if ((uses_rs1 && 32'(ra1) >= NREGS) || (uses_rs2 && 32'(ra2) >= NREGS) ||
            (has_rd && 32'(rd_idx) >= NREGS)) begin
            ctrl_dec.illegal = 1'b1;
            ctrl_dec.we3     = 1'b0;
            ctrl_dec.wem     = 1'b0;
        end
    end

    // ---------------- ID: register file read ----------------
    always_comb begin
        rd1_val = rf[ra1[AW-1:0]];
        rd2_val = rf[ra2[AW-1:0]];
`ifdef ID_BYPASS_EN
        if (we3_in && wa3_in == ra1) rd1_val = wd3_in;
        if (we3_in && wa3_in == ra2) rd2_val = wd3_in;
`endif
        if (ra1 == 5'd0) rd1_val = '0;
        if (ra2 == 5'd0) rd2_val = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (we3_in && wa3_in != 5'd0 && 32'(wa3_in) < NREGS) begin
            rf[wa3_in[AW-1:0]] <= wd3_in;
        end
    end

    id_hazard_unit u_hazard (
        .uses_rs1   (uses_rs1),
        .uses_rs2   (uses_rs2),
        .ra1        (ra1),
        .ra2        (ra2),
        .ex_valid   (vld_p1),
        .ex_is_load (ctrl_p1.is_load),
        .ex_wa3     (wa3_p1),
        .wb_we3     (we3_in),
        .wb_wa3     (wa3_in),
        .lu         (lu),
        .wbh        (wbh)
    );

    assign in_ready = !flush && !(lu || wbh) && (!vld_p1 || out_ready);

    // ---------------- ID/EX register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
            wa3_p1  <= '0;
            imm_p1  <= '0;
            rd1_p1  <= '0;
            rd2_p1  <= '0;
            pc_p1   <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (in_valid && in_ready) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= ctrl_dec;
            wa3_p1  <= has_rd ? rd_idx : 5'd0;
            imm_p1  <= sext32(imm32);
            rd1_p1  <= rd1_val;
            rd2_p1  <= rd2_val;
            pc_p1   <= pc_in;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign ctrl_out  = ctrl_p1;
    assign wa3_out   = wa3_p1;
    assign imm       = imm_p1;
    assign rd1       = rd1_p1;
    assign rd2       = rd2_p1;
    assign pc_out    = pc_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed testbench for id_stage_pipe. Two instances share the stimulus:
// u_dut (RV32I, NREGS=32) and u_dut_e (RV32E, NREGS=16).
module tb_id_stage_pipe;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready, we3_in;
    logic [31:0] instr, pc_in, wd3_in;
    logic [4:0]  wa3_in;

    logic        in_ready, out_valid;
    id_ctrl_t    ctrl_out;
    logic [4:0]  wa3_out;
    logic [31:0] imm, rd1, rd2, pc_out;

    logic        in_ready_e, out_valid_e;
    id_ctrl_t    ctrl_e;
    logic [4:0]  wa3_e;
    logic [31:0] imm_e, rd1_e, rd2_e, pc_e;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] I_LW_X5     = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_ADD_X6_X5 = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] I_ADD_X6_X1 = 32'h00208333; // add  x6,x1,x2
    localparam logic [31:0] I_ADDI_X8   = 32'h00138413; // addi x8,x7,1
    localparam logic [31:0] I_SW        = 32'h0020A223; // sw   x2,4(x1)
    localparam logic [31:0] I_ADDI_X10  = 32'hFFB00513; // addi x10,x0,-5
    localparam logic [31:0] I_ADDI_X11  = 32'h05500593; // addi x11,x0,0x55
    localparam logic [31:0] I_ADD_X20   = 32'h00208A33; // add  x20,x1,x2
    localparam logic [31:0] I_ADD_X9    = 32'h000004B3; // add  x9,x0,x0

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREGS(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .ctrl_out(ctrl_out), .wa3_out(wa3_out), .imm(imm),
        .rd1(rd1), .rd2(rd2), .pc_out(pc_out),
        .we3_in(we3_in), .wa3_in(wa3_in), .wd3_in(wd3_in)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(16)) u_dut_e (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_e),
        .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid_e),
        .out_ready(out_ready), .ctrl_out(ctrl_e), .wa3_out(wa3_e), .imm(imm_e),
        .rd1(rd1_e), .rd2(rd2_e), .pc_out(pc_e),
        .we3_in(we3_in), .wa3_in(wa3_in), .wd3_in(wd3_in)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; instr = I_ADD_X6_X5; pc_in = 32'h100;
        flush = 1'b0; out_ready = 1'b1; we3_in = 1'b0; wa3_in = '0; wd3_in = '0;

        // 1: reset with in_valid high
        step(); step();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_ctrl", 32'(ctrl_out), 32'h0);
        check("rst_wa3", {27'b0, wa3_out}, 32'h0);
        check("rst_imm", imm, 32'h0);
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        in_valid = 1'b0;

        // preload x1, x2; write to x0 must be ignored
        we3_in = 1'b1; wa3_in = 5'd1; wd3_in = 32'h11; step();
        wa3_in = 5'd2; wd3_in = 32'h22; step();
        wa3_in = 5'd0; wd3_in = 32'h1234; step();
        we3_in = 1'b0;

        // 2: load-use -> exactly one bubble
        in_valid = 1'b1; instr = I_LW_X5; pc_in = 32'h200;
        #1 check("lu_lw_ready", {31'b0, in_ready}, 32'h1);
        step();
        check("lu_v0", {31'b0, out_valid}, 32'h1);
        check("lu_is_load", {31'b0, ctrl_out.is_load}, 32'h1);
        check("lu_lw_rd1", rd1, 32'h11);
        instr = I_ADD_X6_X5; pc_in = 32'h204;
        #1 check("lu_stall", {31'b0, in_ready}, 32'h0);
        step();
        check("lu_v1", {31'b0, out_valid}, 32'h0);
        #1 check("lu_resume", {31'b0, in_ready}, 32'h1);
        step();
        check("lu_v2", {31'b0, out_valid}, 32'h1);
        check("lu_add_pc", pc_out, 32'h204);
        check("lu_add_wa3", {27'b0, wa3_out}, 32'h6);
        check("lu_add_rd2", rd2, 32'h22);
        in_valid = 1'b0;
        step();

        // 3: WB writes x7 while addi x8,x7,1 is in ID
        we3_in = 1'b1; wa3_in = 5'd7; wd3_in = 32'hDEADBEEF;
        in_valid = 1'b1; instr = I_ADDI_X8; pc_in = 32'h300;
`ifdef ID_BYPASS_EN
        #1 check("wb_ready", {31'b0, in_ready}, 32'h1);
        step();
        we3_in = 1'b0;
`else
        #1 check("wb_stall", {31'b0, in_ready}, 32'h0);
        step();
        we3_in = 1'b0;
        check("wb_bubble", {31'b0, out_valid}, 32'h0);
        #1 check("wb_resume", {31'b0, in_ready}, 32'h1);
        step();
`endif
        check("wb_valid", {31'b0, out_valid}, 32'h1);
        check("wb_rd1", rd1, 32'hDEADBEEF);
        check("wb_imm", imm, 32'h1);
        in_valid = 1'b0;
        step();

        // 4: EX back-pressure for 3 cycles
        in_valid = 1'b1; instr = I_SW; pc_in = 32'h400;
        step();
        out_ready = 1'b0; instr = I_ADDI_X10; pc_in = 32'h404;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready", {31'b0, in_ready}, 32'h0);
            step();
            check("bp_valid", {31'b0, out_valid}, 32'h1);
            check("bp_pc", pc_out, 32'h400);
            check("bp_imm", imm, 32'h4);
            check("bp_wem", {31'b0, ctrl_out.wem}, 32'h1);
        end
        check("bp_rd1", rd1, 32'h11);
        check("bp_wa3", {27'b0, wa3_out}, 32'h0);
        out_ready = 1'b1;
        #1 check("bp_release", {31'b0, in_ready}, 32'h1);
        step();
        check("bp_next_pc", pc_out, 32'h404);
        check("bp_next_imm", imm, 32'hFFFFFFFB);
        check("bp_next_wa3", {27'b0, wa3_out}, 32'hA);
        check("bp_next_we3", {31'b0, ctrl_out.we3}, 32'h1);

        // 5: flush kills ID/EX and drops the incoming instruction
        instr = I_ADDI_X11; pc_in = 32'h500; flush = 1'b1;
        #1 check("fl_ready", {31'b0, in_ready}, 32'h0);
        step();
        check("fl_v0", {31'b0, out_valid}, 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_v1", {31'b0, out_valid}, 32'h0);
        step();
        check("fl_v2", {31'b0, out_valid}, 32'h0);

        // 6: RV32E out-of-range register and x0 handling
        in_valid = 1'b1; instr = I_ADD_X20; pc_in = 32'h600;
        step();
        check("e_valid", {31'b0, out_valid_e}, 32'h1);
        check("e_illegal", {31'b0, ctrl_e.illegal}, 32'h1);
        check("e_we3", {31'b0, ctrl_e.we3}, 32'h0);
        check("e_rd1", rd1_e, 32'h11);
        check("e_rd2", rd2_e, 32'h22);
        check("e_wa3", {27'b0, wa3_e}, 32'h14);
        check("e_imm", imm_e, 32'h0);
        check("e_pc", pc_e, 32'h600);
        check("i_illegal", {31'b0, ctrl_out.illegal}, 32'h0);
        check("i_we3", {31'b0, ctrl_out.we3}, 32'h1);
        we3_in = 1'b1; wa3_in = 5'd0; wd3_in = 32'hCAFE;
        instr = I_ADD_X9; pc_in = 32'h604;
        #1 check("x0_ready", {31'b0, in_ready}, 32'h1);
        check("x0_ready_e", {31'b0, in_ready_e}, 32'h1);
        step();
        we3_in = 1'b0;
        check("x0_rd1", rd1, 32'h0);
        check("x0_rd2", rd2, 32'h0);
        check("x0_pc", pc_out, 32'h604);
        in_valid = 1'b0;
        step();

        // 7: reset during stall + back-pressure, no replay, regfile cleared
        in_valid = 1'b1; instr = I_LW_X5; pc_in = 32'h700;
        step();
        out_ready = 1'b0; instr = I_ADD_X6_X5; pc_in = 32'h704;
        step();
        reset = 1'b1;
        #1 check("mr_valid", {31'b0, out_valid}, 32'h0);
        check("mr_pc", pc_out, 32'h0);
        step();
        reset = 1'b0; out_ready = 1'b1; instr = I_ADD_X6_X1;
        #1 check("mr_ready", {31'b0, in_ready}, 32'h1);
        step();
        check("mr_v", {31'b0, out_valid}, 32'h1);
        check("mr_wa3", {27'b0, wa3_out}, 32'h6);
        check("mr_rd1", rd1, 32'h0);
        check("mr_rd2", rd2, 32'h0);
        check("mr_pc2", pc_out, 32'h704);
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
